// File: rtl/hcsr04_emulador_pkg.sv
// Shared definitions for the HC-SR04 emulator: FSM state codes, default
// timing constants and the width of the single shared counter.
package hcsr04_pkg;

  localparam int CNT_W = 21;

  localparam int DEF_TRIG_MIN_CYC = 500;
  localparam int DEF_HOLDOFF_CYC  = 10000;
  localparam int DEF_TICKS_PER_CM = 2941;
  localparam int DEF_MAX_CM       = 400;
  localparam int DEF_TIMEOUT_CYC  = 1900000;
  localparam int DEF_RECOVERY_CYC = 50000;

  typedef enum logic [3:0] {
    OCIOSO       = 4'b0000,
    MEDE_TRIGGER = 4'b0001,
    ATRASO       = 4'b0010,
    ECO          = 4'b0011,
    RECUPERA     = 4'b0100
  } estado_t;

  localparam logic [3:0] DB_ILEGAL = 4'b1110;

  // Debug code of a state; any encoding outside the enum reads as DB_ILEGAL.
  function automatic logic [3:0] db_code(input estado_t s);
    case (s)
      OCIOSO, MEDE_TRIGGER, ATRASO, ECO, RECUPERA: db_code = 4'(s);
      default:                                     db_code = DB_ILEGAL;
    endcase
  endfunction

endpackage

// File: rtl/hcsr04_emulador_if.sv
// Pin-level trigger/echo bundle between the initiator (master) and the
// emulated sensor (slave).
interface hcsr04_emulador_if;
  logic       trigger;
  logic [8:0] distancia;
  logic       echo;
  logic       ocupado;
  logic [3:0] db_estado;

  modport master (
    output trigger, distancia,
    input  echo, ocupado, db_estado
  );

  modport slave (
    input  trigger, distancia,
    output echo, ocupado, db_estado
  );
endinterface

// File: rtl/hcsr04_emulador_sync_2ff.sv
// Two-flop synchronizer for the asynchronous trigger pin; both stages reset
// high so a trigger held at reset release never looks like a fresh edge.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  // Two-stage resynchronization into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/hcsr04_emulador.sv
// HC-SR04 sensor emulator: answers a valid trigger with an echo pulse whose
// width encodes distancia. Define HCSR04_EMU_SYNC_EN to synchronize trigger.
module hcsr04_emulador
  import hcsr04_pkg::*;
#(
  parameter int TRIG_MIN_CYC = DEF_TRIG_MIN_CYC,
  parameter int HOLDOFF_CYC  = DEF_HOLDOFF_CYC,
  parameter int TICKS_PER_CM = DEF_TICKS_PER_CM,
  parameter int MAX_CM       = DEF_MAX_CM,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC
) (
  input  logic             clock,
  input  logic             reset,
  hcsr04_emulador_if.slave bus
);
  localparam logic [CNT_W-1:0] TRIG_MIN_C    = CNT_W'(TRIG_MIN_CYC);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST  = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C     = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_CYC - 1);
  localparam logic [11:0]      TICKS_C       = 12'(TICKS_PER_CM);
  localparam logic [8:0]       MAX_C         = 9'(MAX_CM);

  logic trig_s;

`ifdef HCSR04_EMU_SYNC_EN
  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.trigger),
    .q     (trig_s)
  );
`else
  assign trig_s = bus.trigger;
`endif

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] contador_q, contador_d;
  logic [8:0]       dist_q, dist_d;
  logic             echo_q, echo_d;
  logic             ocupado_q, ocupado_d;
  logic             trig_ant_q, trig_ant_d;
  logic [CNT_W-1:0] n_s;

  // Echo width for the latched distance; 0 and out-of-range map to timeout.
  always_comb begin
    if ((dist_q != 9'd0) && (dist_q <= MAX_C)) begin
      n_s = CNT_W'(dist_q) * CNT_W'(TICKS_C);
    end else begin
      n_s = TIMEOUT_C;
    end
  end

  // Next-state, counter and registered-output logic of the response FSM.
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    dist_d     = dist_q;
    echo_d     = 1'b0;
    ocupado_d  = 1'b0;
    trig_ant_d = trig_s;
    case (estado_q)
      OCIOSO: begin
        if (trig_s && !trig_ant_q) begin
          estado_d   = MEDE_TRIGGER;
          contador_d = 21'd1;
        end else begin
          contador_d = 21'd0;
        end
      end
      MEDE_TRIGGER: begin
        if (trig_s) begin
          if (contador_q < TRIG_MIN_C) begin
            contador_d = contador_q + 21'd1;
          end else begin
            contador_d = contador_q;
          end
        end else if (contador_q >= TRIG_MIN_C) begin
          dist_d     = bus.distancia;
          contador_d = 21'd0;
          estado_d   = ATRASO;
          ocupado_d  = 1'b1;
        end else begin
          contador_d = 21'd0;
          estado_d   = OCIOSO;
        end
      end
      ATRASO: begin
        ocupado_d = 1'b1;
        if (contador_q == HOLDOFF_LAST) begin
          contador_d = 21'd0;
          estado_d   = ECO;
        end else begin
          contador_d = contador_q + 21'd1;
        end
      end
      ECO: begin
        // echo goes high one edge after entering ECO and stays for n_s edges.
        ocupado_d = 1'b1;
        if (contador_q == n_s) begin
          contador_d = 21'd0;
          estado_d   = RECUPERA;
        end else begin
          echo_d     = 1'b1;
          contador_d = contador_q + 21'd1;
        end
      end
      RECUPERA: begin
        if (contador_q == RECOVERY_LAST) begin
          contador_d = 21'd0;
          estado_d   = OCIOSO;
        end else begin
          ocupado_d  = 1'b1;
          contador_d = contador_q + 21'd1;
        end
      end
      default: begin
        contador_d = 21'd0;
        estado_d   = OCIOSO;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      contador_q <= 21'd0;
      dist_q     <= 9'd0;
      echo_q     <= 1'b0;
      ocupado_q  <= 1'b0;
      trig_ant_q <= 1'b1;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      dist_q     <= dist_d;
      echo_q     <= echo_d;
      ocupado_q  <= ocupado_d;
      trig_ant_q <= trig_ant_d;
    end
  end

  assign bus.echo      = echo_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.db_estado = db_code(estado_q);
endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed self-checking bench for hcsr04_emulador with shortened timing;
// echo latency expectations track HCSR04_EMU_SYNC_EN.
module tb_hcsr04_emulador;
  localparam int TRIG_MIN = 5;
  localparam int HOLDOFF  = 8;
  localparam int TICKS    = 4;
  localparam int MAXCM    = 400;
  localparam int TIMEOUT  = 100;
  localparam int RECOV    = 10;
  localparam int BUDGET   = 5000;
`ifdef HCSR04_EMU_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int EXP_RISE = HOLDOFF + 1 + SYNC_LAT;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  hcsr04_emulador_if bus_if ();

  hcsr04_emulador #(
    .TRIG_MIN_CYC (TRIG_MIN),
    .HOLDOFF_CYC  (HOLDOFF),
    .TICKS_PER_CM (TICKS),
    .MAX_CM       (MAXCM),
    .TIMEOUT_CYC  (TIMEOUT),
    .RECOVERY_CYC (RECOV)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input int w);
    bus_if.trigger = 1'b1;
    repeat (w) tick;
    bus_if.trigger = 1'b0;
  endtask

  // Called right after pulse(): returns edges from T to echo rise, echo width
  // and edges from echo fall to ocupado fall.
  task automatic measure(input bit perturb, output int rise, output int width, output int recov);
    tick;
    rise = 0;
    while (bus_if.echo !== 1'b1 && rise < BUDGET) begin
      tick;
      rise++;
    end
    width = 0;
    while (bus_if.echo === 1'b1 && width < BUDGET) begin
      if (perturb) begin
        if (width == 5)  bus_if.trigger = 1'b1;
        if (width == 12) bus_if.trigger = 1'b0;
        if (width == 15) bus_if.distancia = 9'd200;
      end
      tick;
      width++;
    end
    recov = 0;
    while (bus_if.ocupado === 1'b1 && recov < BUDGET) begin
      if (perturb) begin
        if (recov == 1) bus_if.trigger = 1'b1;
        if (recov == 6) bus_if.trigger = 1'b0;
      end
      tick;
      recov++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus_if.trigger = 1'b0;
    bus_if.distancia = 9'd0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (bus_if.echo !== 1'b0 || bus_if.ocupado !== 1'b0 || bus_if.db_estado !== 4'b0000) begin
      $display("FAIL reset_state: echo=%b ocupado=%b db=%b expected 0 0 0000",
               bus_if.echo, bus_if.ocupado, bus_if.db_estado);
      n_fail++;
    end
    reset = 1'b1;
    tick;
    n_checks++;
    if (bus_if.db_estado !== 4'b0000) begin
      $display("FAIL reset_release_state: db=%b expected 0000", bus_if.db_estado);
      n_fail++;
    end
  endtask

  task automatic test_nominal;
    int rise, width, recov, extra;
    bus_if.distancia = 9'd25;
    pulse(6);
    measure(1'b0, rise, width, recov);
    n_checks++;
    if (rise !== EXP_RISE) begin
      $display("FAIL nominal_rise: got %0d expected %0d", rise, EXP_RISE);
      n_fail++;
    end
    n_checks++;
    if (width !== 100) begin
      $display("FAIL nominal_width: got %0d expected 100", width);
      n_fail++;
    end
    n_checks++;
    if (recov !== RECOV) begin
      $display("FAIL nominal_recovery: got %0d expected %0d", recov, RECOV);
      n_fail++;
    end
    n_checks++;
    if (bus_if.db_estado !== 4'b0000) begin
      $display("FAIL nominal_end_state: db=%b expected 0000", bus_if.db_estado);
      n_fail++;
    end
    extra = 0;
    repeat (30) begin
      tick;
      if (bus_if.echo === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      $display("FAIL nominal_no_second_echo: got %0d echo cycles expected 0", extra);
      n_fail++;
    end
  endtask

  task automatic test_runt;
    int echo_cnt, busy_cnt;
    bus_if.distancia = 9'd25;
    pulse(TRIG_MIN - 1);
    echo_cnt = 0;
    busy_cnt = 0;
    repeat (40) begin
      tick;
      if (bus_if.echo === 1'b1) echo_cnt++;
      if (bus_if.ocupado === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (echo_cnt !== 0 || busy_cnt !== 0) begin
      $display("FAIL runt_ignored: echo cycles %0d ocupado cycles %0d expected 0 0", echo_cnt, busy_cnt);
      n_fail++;
    end
    n_checks++;
    if (bus_if.db_estado !== 4'b0000) begin
      $display("FAIL runt_state: db=%b expected 0000", bus_if.db_estado);
      n_fail++;
    end
  endtask

  task automatic test_boundaries;
    int dists[4]  = '{0, 401, 400, 1};
    int widths[4] = '{100, 100, 1600, 4};
    int trigw[4]  = '{6, 6, 6, TRIG_MIN};
    int rise, width, recov;
    for (int i = 0; i < 4; i++) begin
      bus_if.distancia = 9'(dists[i]);
      pulse(trigw[i]);
      measure(1'b0, rise, width, recov);
      n_checks++;
      if (width !== widths[i]) begin
        $display("FAIL boundary_width_d%0d: got %0d expected %0d", dists[i], width, widths[i]);
        n_fail++;
      end
      n_checks++;
      if (rise !== EXP_RISE || recov !== RECOV) begin
        $display("FAIL boundary_timing_d%0d: rise %0d recov %0d expected %0d %0d",
                 dists[i], rise, recov, EXP_RISE, RECOV);
        n_fail++;
      end
    end
  endtask

  task automatic test_ignored_activity;
    int rise, width, recov, extra;
    bus_if.distancia = 9'd10;
    pulse(6);
    measure(1'b1, rise, width, recov);
    n_checks++;
    if (width !== 40) begin
      $display("FAIL ignored_width: got %0d expected 40", width);
      n_fail++;
    end
    n_checks++;
    if (recov !== RECOV) begin
      $display("FAIL ignored_recovery: got %0d expected %0d", recov, RECOV);
      n_fail++;
    end
    extra = 0;
    repeat (40) begin
      tick;
      if (bus_if.echo === 1'b1 || bus_if.ocupado === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      $display("FAIL ignored_no_second_echo: got %0d active cycles expected 0", extra);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_echo;
    int waitc, active, rise, width, recov;
    bus_if.distancia = 9'd400;
    pulse(6);
    waitc = 0;
    while (bus_if.echo !== 1'b1 && waitc < BUDGET) begin
      tick;
      waitc++;
    end
    repeat (20) tick;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus_if.echo !== 1'b0 || bus_if.ocupado !== 1'b0 || bus_if.db_estado !== 4'b0000) begin
      $display("FAIL reset_mid_echo: echo=%b ocupado=%b db=%b expected 0 0 0000",
               bus_if.echo, bus_if.ocupado, bus_if.db_estado);
      n_fail++;
    end
    bus_if.trigger = 1'b1;
    tick;
    reset = 1'b1;
    active = 0;
    repeat (20) begin
      tick;
      if (bus_if.db_estado !== 4'b0000 || bus_if.ocupado === 1'b1) active++;
    end
    bus_if.trigger = 1'b0;
    repeat (40) begin
      tick;
      if (bus_if.echo === 1'b1 || bus_if.ocupado === 1'b1) active++;
    end
    n_checks++;
    if (active !== 0) begin
      $display("FAIL held_trigger_ignored: got %0d active cycles expected 0", active);
      n_fail++;
    end
    pulse(6);
    measure(1'b0, rise, width, recov);
    n_checks++;
    if (rise !== EXP_RISE || width !== 1600) begin
      $display("FAIL post_reset_response: rise %0d width %0d expected %0d 1600", rise, width, EXP_RISE);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset;
    test_nominal;
    test_runt;
    test_boundaries;
    test_ignored_activity;
    test_reset_mid_echo;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
